qdr_nibble_deser: RTL and testbench



---
 rtl/qdr_lvds_pkg.sv | 27 ++
 rtl/sat_counter.sv | 28 ++
 rtl/qdr_nibble_deser.sv | 182 ++++++++++++++++++
 tb/tb_qdr_nibble_deser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_lvds_pkg.sv
// Shared constants and types for the QDR LVDS nibble link (serializer and deserializer).
package qdr_lvds_pkg;

    localparam int NIB_W         = 4;
    localparam int WORD_W        = 14;
    localparam int NIBS_PER_WORD = 4;
    localparam int PAD_W         = 2;

    // daframe level expected on each nibble, MSB = n0.
    localparam logic [NIBS_PER_WORD-1:0] FRAME_PATTERN = 4'b1100;

    typedef enum logic [2:0] {
        HUNT,
        S0,
        S1,
        S2,
        S3
    } deser_state_t;

    // Expected daframe level for nibble position idx (0 = first nibble of the word).
    function automatic logic frame_expected(input logic [1:0] idx);
        logic [1:0] bit_pos;
        bit_pos = 2'(NIBS_PER_WORD - 1) - idx;
        return FRAME_PATTERN[bit_pos];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX, with synchronous clear and synchronous active-high reset.
module sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Clear wins over increment; increment stops once MAX is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q < MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/qdr_nibble_deser.sv
// Receive-side QDR nibble deserializer: rebuilds 14-bit words from the DA nibble
// stream, checks DAFRAME alignment and pad bits, tracks lock and counts errors.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   HUNT  | unaligned; waiting for a 0->1 daframe edge to capture n0
//   S0    | aligned; expecting n0 (daframe=1)
//   S1    | expecting n1 (daframe=1)
//   S2    | expecting n2 (daframe=0)
//   S3    | expecting n3 (daframe=0, pad checked when CHECK_PAD)
import qdr_lvds_pkg::*;

module qdr_nibble_deser #(
    parameter int LOCK_WORDS = 4,
    parameter int ERR_CNT_W  = 8,
    parameter bit CHECK_PAD  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIB_W-1:0]     da,
    input  logic                 daframe,
    input  logic                 da_valid,
    output logic [WORD_W-1:0]    data_out,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_WORDS);

    deser_state_t        state_q, state_d;
    logic                prev_frame_q;
    logic [NIB_W-1:0]    n0_q, n0_d;
    logic [NIB_W-1:0]    n1_q, n1_d;
    logic [NIB_W-1:0]    n2_q, n2_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                out_valid_q;
    logic                sync_err_q;
    logic                locked_q, locked_d;
    logic                good_word;
    logic                frame_err;
    logic                pad_bad;
    logic [3:0]          lock_cnt;

    assign pad_bad = CHECK_PAD && (da[PAD_W-1:0] != '0);

    // Next-state, nibble capture and error/good-word decode for the current nibble.
    always_comb begin
        state_d   = state_q;
        n0_d      = n0_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        good_word = 1'b0;
        frame_err = 1'b0;

        if (da_valid) begin
            unique case (state_q)
                HUNT: begin
                    // The erroring nibble never lands here, so a frame edge on it
                    // is not reused as n0: prev_frame is already 1 by then.
                    if (daframe && !prev_frame_q) begin
                        n0_d    = da;
                        state_d = S1;
                    end
                end
                S0: begin
                    if (daframe == frame_expected(2'd0)) begin
                        n0_d    = da;
                        state_d = S1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                S1: begin
                    if (daframe == frame_expected(2'd1)) begin
                        n1_d    = da;
                        state_d = S2;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                S2: begin
                    if (daframe == frame_expected(2'd2)) begin
                        n2_d    = da;
                        state_d = S3;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                S3: begin
                    if ((daframe == frame_expected(2'd3)) && !pad_bad) begin
                        good_word = 1'b1;
                        state_d   = S0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase

            if (frame_err) begin
                state_d = HUNT;
            end
        end
    end

    // Output word assembly and lock flag; locked rises together with the
    // out_valid of the word that brings the lock counter to LOCK_WORDS.
    always_comb begin
        data_out_d = data_out_q;
        locked_d   = locked_q;
        if (good_word) begin
            data_out_d = {n0_q, n1_q, n2_q, da[NIB_W-1:PAD_W]};
            locked_d   = (lock_cnt >= (LOCK_MAX - 4'd1));
        end else if (frame_err) begin
            locked_d   = 1'b0;
        end
    end

    // FSM state, frame history and partial-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            prev_frame_q <= 1'b1;
            n0_q         <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
        end else begin
            state_q <= state_d;
            n0_q    <= n0_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            if (da_valid) begin
                prev_frame_q <= daframe;
            end
        end
    end

    // Registered outputs: word, one-cycle pulses and lock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= good_word;
            sync_err_q  <= frame_err;
            locked_q    <= locked_d;
        end
    end

    sat_counter #(
        .W   (4),
        .MAX (LOCK_MAX)
    ) u_lock_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (frame_err),
        .inc   (good_word),
        .cnt   (lock_cnt)
    );

    sat_counter #(
        .W   (ERR_CNT_W),
        .MAX ({ERR_CNT_W{1'b1}})
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (frame_err),
        .cnt   (err_count)
    );

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_qdr_nibble_deser.sv
// Bench for qdr_nibble_deser: two instances (pad checking on / off) share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_qdr_nibble_deser;

    logic        clk;
    logic        reset;
    logic [3:0]  da;
    logic        daframe;
    logic        da_valid;

    logic [13:0] dout   [2];
    logic        ov     [2];
    logic        lk     [2];
    logic        se     [2];
    logic [7:0]  ec     [2];

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // model state, index 0 = CHECK_PAD 1, index 1 = CHECK_PAD 0
    bit          pad_chk [2] = '{1'b1, 1'b0};
    int          m_pos   [2];           // -1 = hunting, else nibbles already collected
    logic        m_prev  [2];
    logic [3:0]  m_nib   [2][4];
    logic [13:0] m_data  [2];
    logic        m_ov    [2];
    logic        m_se    [2];
    logic        m_lk    [2];
    int          m_lc    [2];
    int          m_ec    [2];

    qdr_nibble_deser #(.LOCK_WORDS(4), .ERR_CNT_W(8), .CHECK_PAD(1'b1)) dut_pad (
        .clk(clk), .reset(reset), .da(da), .daframe(daframe), .da_valid(da_valid),
        .data_out(dout[0]), .out_valid(ov[0]), .locked(lk[0]), .sync_err(se[0]),
        .err_count(ec[0])
    );

    qdr_nibble_deser #(.LOCK_WORDS(4), .ERR_CNT_W(8), .CHECK_PAD(1'b0)) dut_nopad (
        .clk(clk), .reset(reset), .da(da), .daframe(daframe), .da_valid(da_valid),
        .data_out(dout[1]), .out_valid(ov[1]), .locked(lk[1]), .sync_err(se[1]),
        .err_count(ec[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic rst, input logic v,
                              input logic f, input logic [3:0] d);
        bit err;
        if (rst) begin
            m_pos[k] = -1; m_prev[k] = 1'b1; m_data[k] = '0;
            m_ov[k] = 1'b0; m_se[k] = 1'b0; m_lk[k] = 1'b0; m_lc[k] = 0; m_ec[k] = 0;
            return;
        end
        m_ov[k] = 1'b0;
        m_se[k] = 1'b0;
        if (!v) return;
        err = 1'b0;
        if (m_pos[k] < 0) begin
            if (f && !m_prev[k]) begin
                m_nib[k][0] = d;
                m_pos[k] = 1;
            end
        end else if (f != (m_pos[k] < 2)) begin
            err = 1'b1;
        end else if (m_pos[k] == 3 && pad_chk[k] && d[1:0] != 2'b00) begin
            err = 1'b1;
        end else begin
            m_nib[k][m_pos[k]] = d;
            m_pos[k] = m_pos[k] + 1;
            if (m_pos[k] == 4) begin
                m_data[k] = {m_nib[k][0], m_nib[k][1], m_nib[k][2], m_nib[k][3][3:2]};
                m_ov[k] = 1'b1;
                m_lc[k] = (m_lc[k] < 4) ? m_lc[k] + 1 : 4;
                m_lk[k] = (m_lc[k] == 4);
                m_pos[k] = 0;
            end
        end
        if (err) begin
            m_se[k] = 1'b1;
            if (m_ec[k] < 255) m_ec[k] = m_ec[k] + 1;
            m_lk[k] = 1'b0;
            m_lc[k] = 0;
            m_pos[k] = -1;
        end
        m_prev[k] = f;
    endtask

    // apply inputs, let the DUTs sample them, advance the model, settle
    task automatic drive(input logic rst, input logic v, input logic f, input logic [3:0] d);
        reset = rst; da_valid = v; daframe = f; da = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, rst, v, f, d);
        #1;
    endtask

    task automatic gap(input int maxgap);
        int n;
        n = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (n) drive(1'b0, 1'b0, 1'($urandom), 4'($urandom));
    endtask

    task automatic send_word(input logic [13:0] w, input logic [1:0] pad, input int maxgap);
        logic [3:0] nib [4];
        nib[0] = w[13:10];
        nib[1] = w[9:6];
        nib[2] = w[5:2];
        nib[3] = {w[1:0], pad};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, (i < 2), nib[i]);
            if (i < 3) gap(maxgap);
        end
    endtask

    // cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("data_out",  k, 32'(dout[k]), 32'(m_data[k]));
                chk("out_valid", k, 32'(ov[k]),   32'(m_ov[k]));
                chk("locked",    k, 32'(lk[k]),   32'(m_lk[k]));
                chk("sync_err",  k, 32'(se[k]),   32'(m_se[k]));
                chk("err_count", k, 32'(ec[k]),   32'(m_ec[k]));
            end
        end
    end

    logic [13:0] lock_words [4] = '{14'h0000, 14'h3FFF, 14'h1234, 14'h2A5C};

    initial begin
        reset = 1'b1; da_valid = 1'b0; daframe = 1'b0; da = '0;
        #1;
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        started = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            chk("rst_data",   k, 32'(dout[k]), 32'h0);
            chk("rst_valid",  k, 32'(ov[k]),   32'h0);
            chk("rst_locked", k, 32'(lk[k]),   32'h0);
            chk("rst_err",    k, 32'(ec[k]),   32'h0);
        end

        // basic word A,9,7,0
        drive(1'b0, 1'b1, 1'b0, 4'h5);
        drive(1'b0, 1'b1, 1'b1, 4'hA);
        drive(1'b0, 1'b1, 1'b1, 4'h9);
        drive(1'b0, 1'b1, 1'b0, 4'h7);
        for (int k = 0; k < 2; k++) chk("basic_early", k, 32'(ov[k]), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            chk("basic_valid", k, 32'(ov[k]),   32'h1);
            chk("basic_data",  k, 32'(dout[k]), 32'h2A5C);
            chk("basic_serr",  k, 32'(se[k]),   32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 2; k++) chk("basic_hold", k, 32'(dout[k]), 32'h2A5C);

        // lock acquisition from a fresh reset, with gaps
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 4; i++) begin
            send_word(lock_words[i], 2'b00, 3);
            for (int k = 0; k < 2; k++) begin
                chk("lock_data",   k, 32'(dout[k]), 32'(lock_words[i]));
                chk("lock_valid",  k, 32'(ov[k]),   32'h1);
                chk("lock_locked", k, 32'(lk[k]),   32'(i == 3));
            end
            gap(3);
        end

        // frame slip on the third nibble
        drive(1'b0, 1'b1, 1'b1, 4'h1);
        drive(1'b0, 1'b1, 1'b1, 4'h2);
        drive(1'b0, 1'b1, 1'b1, 4'h3);
        for (int k = 0; k < 2; k++) begin
            chk("slip_serr",   k, 32'(se[k]), 32'h1);
            chk("slip_count",  k, 32'(ec[k]), 32'h1);
            chk("slip_locked", k, 32'(lk[k]), 32'h0);
            chk("slip_valid",  k, 32'(ov[k]), 32'h0);
        end
        drive(1'b0, 1'b1, 1'b0, 4'h6);
        send_word(14'h1E5B, 2'b00, 0);
        for (int k = 0; k < 2; k++) chk("slip_recover", k, 32'(dout[k]), 32'h1E5B);

        // pad error: only the pad-checking instance rejects it
        send_word(14'h1ABC, 2'b01, 0);
        chk("pad_serr",   0, 32'(se[0]),   32'h1);
        chk("pad_drop",   0, 32'(ov[0]),   32'h0);
        chk("pad_count",  0, 32'(ec[0]),   32'h2);
        chk("nopad_val",  1, 32'(ov[1]),   32'h1);
        chk("nopad_data", 1, 32'(dout[1]), 32'h1ABC);

        // randomized mix of clean words and junk nibbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                send_word(14'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00, 2);
            end else begin
                drive(1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
            end
        end

        // saturation: alternating frame levels error every other nibble
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        repeat (300) begin
            drive(1'b0, 1'b1, 1'b1, 4'($urandom));
            drive(1'b0, 1'b1, 1'b0, 4'($urandom));
        end
        for (int k = 0; k < 2; k++) chk("sat_count", k, 32'(ec[k]), 32'hFF);
        repeat (5) begin
            drive(1'b0, 1'b1, 1'b1, 4'h1);
            drive(1'b0, 1'b1, 1'b0, 4'h2);
        end
        for (int k = 0; k < 2; k++) begin
            chk("sat_hold", k, 32'(ec[k]), 32'hFF);
            chk("sat_serr", k, 32'(se[k]), 32'h1);
        end

        // reset in the middle of a word
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 1'b1, 4'hA);
        drive(1'b0, 1'b1, 1'b1, 4'hB);
        drive(1'b1, 1'b1, 1'b0, 4'hC);
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_data",  k, 32'(dout[k]), 32'h0);
            chk("mid_rst_count", k, 32'(ec[k]),   32'h0);
            chk("mid_rst_serr",  k, 32'(se[k]),   32'h0);
            chk("mid_rst_lock",  k, 32'(lk[k]),   32'h0);
        end
        send_word(14'h2A5C, 2'b00, 0);
        for (int k = 0; k < 2; k++) begin
            chk("lead_frame_valid", k, 32'(ov[k]),   32'h0);
            chk("lead_frame_data",  k, 32'(dout[k]), 32'h0);
            chk("lead_frame_err",   k, 32'(ec[k]),   32'h0);
        end
        send_word(14'h0C3F, 2'b00, 0);
        for (int k = 0; k < 2; k++) chk("post_rst_word", k, 32'(dout[k]), 32'h0C3F);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);

        @(negedge clk);
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
